// File: rtl/ats21_client_scheduler.sv
// Pairs one pending instruction from each of two clients into a single ATS21
// transaction (high halves with req, then low halves) and routes the response back.
module ats21_client_scheduler #(
  parameter int PAIR_WAIT = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_instr,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_instr,
  output logic        a_rsp_valid,
  output logic [1:0]  a_rsp_stat,
  output logic [23:0] a_rsp_data,
  output logic        a_rsp_tmo,
  output logic        b_rsp_valid,
  output logic [1:0]  b_rsp_stat,
  output logic [23:0] b_rsp_data,
  output logic        b_rsp_tmo,
  output logic        ats_req,
  output logic [15:0] ats_ctrlA,
  output logic [15:0] ats_ctrlB,
  input  logic        ats_ready,
  input  logic [1:0]  ats_stat,
  input  logic [23:0] ats_data,
  output logic        busy,
  output logic [2:0]  fsm_state
);

  localparam int WAIT_W = $clog2(PAIR_WAIT + 2);
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WORD1  = 3'd1,
    WORD2  = 3'd2,
    S_WAIT = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t            state;
  logic [31:0]       slot_a, slot_b;
  logic              a_full, b_full;
  logic              part_a, part_b;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              issue, finish;
  logic [1:0]        cap_stat;
  logic [23:0]       cap_data;

  // Client handshake: an instruction transfers on a clock edge where valid && ready.
  // valid must hold with stable instr until that edge; ready only rises in IDLE with an empty slot.
  assign a_ready   = !a_full && (state == IDLE);
  assign b_ready   = !b_full && (state == IDLE);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // A lone instruction goes out once it has waited PAIR_WAIT idle cycles.
  assign issue    = (a_full && b_full) ||
                    ((a_full || b_full) && (wait_cnt == WAIT_W'(PAIR_WAIT)));
  assign finish   = ats_ready || (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign cap_stat = ats_ready ? ats_stat : 2'b11;
  assign cap_data = ats_ready ? ats_data : 24'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      slot_a      <= '0;
      slot_b      <= '0;
      a_full      <= 1'b0;
      b_full      <= 1'b0;
      part_a      <= 1'b0;
      part_b      <= 1'b0;
      wait_cnt    <= '0;
      tmo_cnt     <= '0;
      ats_req     <= 1'b0;
      ats_ctrlA   <= '0;
      ats_ctrlB   <= '0;
      a_rsp_valid <= 1'b0;
      a_rsp_stat  <= '0;
      a_rsp_data  <= '0;
      a_rsp_tmo   <= 1'b0;
      b_rsp_valid <= 1'b0;
      b_rsp_stat  <= '0;
      b_rsp_data  <= '0;
      b_rsp_tmo   <= 1'b0;
    end else begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      if (a_valid && a_ready) begin
        slot_a <= a_instr;
        a_full <= 1'b1;
      end
      if (b_valid && b_ready) begin
        slot_b <= b_instr;
        b_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          // Participation is fixed from the slot flags before this edge's loads.
          if (issue) begin
            state     <= WORD1;
            part_a    <= a_full;
            part_b    <= b_full;
            wait_cnt  <= '0;
            ats_req   <= 1'b1;
            ats_ctrlA <= a_full ? slot_a[31:16] : 16'd0;
            ats_ctrlB <= b_full ? slot_b[31:16] : 16'd0;
          end else if (a_full || b_full) begin
            wait_cnt <= wait_cnt + 1'b1;
          end else begin
            wait_cnt <= '0;
          end
        end
        WORD1: begin
          state     <= WORD2;
          ats_req   <= 1'b0;
          ats_ctrlA <= part_a ? slot_a[15:0] : 16'd0;
          ats_ctrlB <= part_b ? slot_b[15:0] : 16'd0;
        end
        WORD2: begin
          state     <= S_WAIT;
          ats_ctrlA <= '0;
          ats_ctrlB <= '0;
          tmo_cnt   <= '0;
        end
        S_WAIT: begin
          if (finish) begin
            state       <= RESP;
            a_rsp_valid <= part_a;
            b_rsp_valid <= part_b;
            if (part_a) begin
              a_rsp_stat <= cap_stat;
              a_rsp_data <= cap_data;
              a_rsp_tmo  <= !ats_ready;
            end
            if (part_b) begin
              b_rsp_stat <= cap_stat;
              b_rsp_data <= cap_data;
              b_rsp_tmo  <= !ats_ready;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          if (part_a) a_full <= 1'b0;
          if (part_b) b_full <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ats21_client_scheduler.sv
// Directed bench for ats21_client_scheduler: pairing, lone issue, late partner,
// timeout, busy hold-off and reset abandonment, each with hand-computed expectations.
module tb_ats21_client_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [31:0] a_instr, b_instr;
  logic        a_rsp_valid, b_rsp_valid;
  logic [1:0]  a_rsp_stat, b_rsp_stat;
  logic [23:0] a_rsp_data, b_rsp_data;
  logic        a_rsp_tmo, b_rsp_tmo;
  logic        ats_req;
  logic [15:0] ats_ctrlA, ats_ctrlB;
  logic        ats_ready;
  logic [1:0]  ats_stat;
  logic [23:0] ats_data;
  logic        busy;
  logic [2:0]  fsm_state;

  int total = 0;
  int bad   = 0;

  ats21_client_scheduler #(.PAIR_WAIT(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_instr(a_instr),
    .b_valid(b_valid), .b_ready(b_ready), .b_instr(b_instr),
    .a_rsp_valid(a_rsp_valid), .a_rsp_stat(a_rsp_stat), .a_rsp_data(a_rsp_data), .a_rsp_tmo(a_rsp_tmo),
    .b_rsp_valid(b_rsp_valid), .b_rsp_stat(b_rsp_stat), .b_rsp_data(b_rsp_data), .b_rsp_tmo(b_rsp_tmo),
    .ats_req(ats_req), .ats_ctrlA(ats_ctrlA), .ats_ctrlB(ats_ctrlB),
    .ats_ready(ats_ready), .ats_stat(ats_stat), .ats_data(ats_data),
    .busy(busy), .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // driver: advance one cycle, land 1ns after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (ats_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", ats_req); end
    reset = 1'b1;
    step();
    total++; if ({a_ready, b_ready} !== 2'b11) begin bad++; $display("FAIL rst_ready got=%b exp=11", {a_ready, b_ready}); end
    total++; if ({ats_ctrlA, ats_ctrlB} !== 32'd0) begin bad++; $display("FAIL rst_ctrl got=%h exp=0", {ats_ctrlA, ats_ctrlB}); end
    total++; if ({a_rsp_valid, b_rsp_valid, a_rsp_stat, b_rsp_stat, a_rsp_data, b_rsp_data, a_rsp_tmo, b_rsp_tmo} !== 56'd0) begin
      bad++; $display("FAIL rst_rsp got=nonzero exp=0"); end
    total++; if (fsm_state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", fsm_state); end
  endtask

  task automatic test_pair();
    a_instr = 32'h2200_0000; b_instr = 32'h2240_0000;
    a_valid = 1'b1; b_valid = 1'b1;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    total++; if (ats_req !== 1'b0) begin bad++; $display("FAIL pair_req_early got=%0b exp=0", ats_req); end
    step();
    total++; if ({ats_req, ats_ctrlA, ats_ctrlB} !== {1'b1, 16'h2200, 16'h2240}) begin
      bad++; $display("FAIL pair_word1 got=%0b/%h/%h exp=1/2200/2240", ats_req, ats_ctrlA, ats_ctrlB); end
    total++; if ({a_ready, b_ready, busy} !== 3'b001) begin bad++; $display("FAIL pair_busy got=%b exp=001", {a_ready, b_ready, busy}); end
    step();
    total++; if ({ats_req, ats_ctrlA, ats_ctrlB} !== 33'd0) begin
      bad++; $display("FAIL pair_word2 got=%0b/%h/%h exp=0/0000/0000", ats_req, ats_ctrlA, ats_ctrlB); end
    step();
    ats_ready = 1'b1; ats_stat = 2'b01; ats_data = 24'h00ABCD;
    step();
    ats_ready = 1'b0;
    total++; if ({a_rsp_valid, b_rsp_valid} !== 2'b11) begin bad++; $display("FAIL pair_rsp_valid got=%b exp=11", {a_rsp_valid, b_rsp_valid}); end
    total++; if ({a_rsp_stat, a_rsp_data, a_rsp_tmo} !== {2'b01, 24'h00ABCD, 1'b0}) begin
      bad++; $display("FAIL pair_a_rsp got=%b/%h/%b exp=01/00abcd/0", a_rsp_stat, a_rsp_data, a_rsp_tmo); end
    total++; if ({b_rsp_stat, b_rsp_data, b_rsp_tmo} !== {2'b01, 24'h00ABCD, 1'b0}) begin
      bad++; $display("FAIL pair_b_rsp got=%b/%h/%b exp=01/00abcd/0", b_rsp_stat, b_rsp_data, b_rsp_tmo); end
    step();
    total++; if ({a_rsp_valid, b_rsp_valid, busy, a_ready, b_ready} !== 5'b00011) begin
      bad++; $display("FAIL pair_after got=%b exp=00011", {a_rsp_valid, b_rsp_valid, busy, a_ready, b_ready}); end
    total++; if (a_rsp_data !== 24'h00ABCD) begin bad++; $display("FAIL pair_hold got=%h exp=00abcd", a_rsp_data); end
  endtask

  task automatic test_lone();
    int early;
    a_instr = 32'hA000_0258; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    early = 0;
    for (int i = 0; i < 5; i++) begin
      if (ats_req !== 1'b0 || busy !== 1'b0) early++;
      step();
    end
    total++; if (early !== 0) begin bad++; $display("FAIL lone_early got=%0d exp=0", early); end
    total++; if ({ats_req, ats_ctrlA, ats_ctrlB} !== {1'b1, 16'hA000, 16'h0000}) begin
      bad++; $display("FAIL lone_word1 got=%0b/%h/%h exp=1/a000/0000", ats_req, ats_ctrlA, ats_ctrlB); end
    step();
    total++; if ({ats_ctrlA, ats_ctrlB} !== {16'h0258, 16'h0000}) begin
      bad++; $display("FAIL lone_word2 got=%h/%h exp=0258/0000", ats_ctrlA, ats_ctrlB); end
    step();
    ats_ready = 1'b1; ats_stat = 2'b10; ats_data = 24'h123456;
    step();
    ats_ready = 1'b0;
    total++; if ({a_rsp_valid, b_rsp_valid} !== 2'b10) begin bad++; $display("FAIL lone_valid got=%b exp=10", {a_rsp_valid, b_rsp_valid}); end
    total++; if ({a_rsp_stat, a_rsp_data} !== {2'b10, 24'h123456}) begin
      bad++; $display("FAIL lone_a_rsp got=%b/%h exp=10/123456", a_rsp_stat, a_rsp_data); end
    total++; if ({b_rsp_stat, b_rsp_data} !== {2'b01, 24'h00ABCD}) begin
      bad++; $display("FAIL lone_b_hold got=%b/%h exp=01/00abcd", b_rsp_stat, b_rsp_data); end
    step();
  endtask

  task automatic test_late_partner();
    int pulses;
    a_instr = 32'h1111_2222; b_instr = 32'h3333_4444;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    step();
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    total++; if (ats_req !== 1'b0) begin bad++; $display("FAIL late_req_early got=%0b exp=0", ats_req); end
    step();
    total++; if ({ats_req, ats_ctrlA, ats_ctrlB} !== {1'b1, 16'h1111, 16'h3333}) begin
      bad++; $display("FAIL late_word1 got=%0b/%h/%h exp=1/1111/3333", ats_req, ats_ctrlA, ats_ctrlB); end
    step();
    total++; if ({ats_ctrlA, ats_ctrlB} !== {16'h2222, 16'h4444}) begin
      bad++; $display("FAIL late_word2 got=%h/%h exp=2222/4444", ats_ctrlA, ats_ctrlB); end
    step();
    ats_ready = 1'b1; ats_stat = 2'b00; ats_data = 24'h0000FF;
    step();
    ats_ready = 1'b0;
    total++; if ({a_rsp_valid, b_rsp_valid, a_rsp_data, b_rsp_data} !== {2'b11, 24'h0000FF, 24'h0000FF}) begin
      bad++; $display("FAIL late_rsp got=%b/%h/%h exp=11/0000ff/0000ff", {a_rsp_valid, b_rsp_valid}, a_rsp_data, b_rsp_data); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (a_rsp_valid || b_rsp_valid || ats_req) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL late_single got=%0d exp=0", pulses); end
  endtask

  task automatic test_timeout();
    int early;
    a_instr = 32'h5555_6666; b_instr = 32'h7777_8888;
    a_valid = 1'b1; b_valid = 1'b1;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step(); step(); step();
    early = 0;
    for (int i = 0; i < 64; i++) begin
      if (a_rsp_valid || b_rsp_valid || !busy) early++;
      step();
    end
    total++; if (early !== 0) begin bad++; $display("FAIL tmo_early got=%0d exp=0", early); end
    total++; if ({a_rsp_valid, b_rsp_valid, a_rsp_tmo, b_rsp_tmo} !== 4'b1111) begin
      bad++; $display("FAIL tmo_flags got=%b exp=1111", {a_rsp_valid, b_rsp_valid, a_rsp_tmo, b_rsp_tmo}); end
    total++; if ({a_rsp_stat, a_rsp_data, b_rsp_stat, b_rsp_data} !== {2'b11, 24'd0, 2'b11, 24'd0}) begin
      bad++; $display("FAIL tmo_payload got=%b/%h/%b/%h exp=11/0/11/0", a_rsp_stat, a_rsp_data, b_rsp_stat, b_rsp_data); end
    step();
    total++; if ({busy, a_ready, b_ready} !== 3'b011) begin bad++; $display("FAIL tmo_idle got=%b exp=011", {busy, a_ready, b_ready}); end
  endtask

  task automatic test_back_to_back();
    a_instr = 32'h0123_4567; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    total++; if ({ats_req, ats_ctrlA, ats_ctrlB} !== {1'b1, 16'h0123, 16'h0000}) begin
      bad++; $display("FAIL b2b_word1 got=%0b/%h/%h exp=1/0123/0000", ats_req, ats_ctrlA, ats_ctrlB); end
    b_instr = 32'hBEEF_0001; b_valid = 1'b1;
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL b2b_holdoff got=%0b exp=0", b_ready); end
    step();
    ats_ready = 1'b1; ats_stat = 2'b01; ats_data = 24'h111111;
    step();
    ats_ready = 1'b0;
    step();
    total++; if ({busy, a_rsp_valid, b_ready} !== 3'b100) begin
      bad++; $display("FAIL b2b_ignore got=%b exp=100", {busy, a_rsp_valid, b_ready}); end
    ats_ready = 1'b1; ats_stat = 2'b10; ats_data = 24'h222222;
    step();
    ats_ready = 1'b0;
    total++; if ({a_rsp_valid, b_rsp_valid, a_rsp_data} !== {2'b10, 24'h222222}) begin
      bad++; $display("FAIL b2b_rsp_a got=%b/%h exp=10/222222", {a_rsp_valid, b_rsp_valid}, a_rsp_data); end
    step();
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b exp=1", b_ready); end
    step();
    b_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    total++; if ({ats_req, ats_ctrlA, ats_ctrlB} !== {1'b1, 16'h0000, 16'hBEEF}) begin
      bad++; $display("FAIL b2b_b_word1 got=%0b/%h/%h exp=1/0000/beef", ats_req, ats_ctrlA, ats_ctrlB); end
    step();
    total++; if (ats_ctrlB !== 16'h0001) begin bad++; $display("FAIL b2b_b_word2 got=%h exp=0001", ats_ctrlB); end
    step();
    ats_ready = 1'b1; ats_stat = 2'b11; ats_data = 24'h333333;
    step();
    ats_ready = 1'b0;
    total++; if ({a_rsp_valid, b_rsp_valid, b_rsp_stat, b_rsp_data, b_rsp_tmo} !== {2'b01, 2'b11, 24'h333333, 1'b0}) begin
      bad++; $display("FAIL b2b_rsp_b got=%b/%b/%h/%b exp=01/11/333333/0", {a_rsp_valid, b_rsp_valid}, b_rsp_stat, b_rsp_data, b_rsp_tmo); end
    step();
  endtask

  task automatic test_reset_mid();
    int stray;
    a_instr = 32'h1234_5678; b_instr = 32'h9ABC_DEF0;
    a_valid = 1'b1; b_valid = 1'b1;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    #1;
    total++; if ({ats_req, busy, a_rsp_valid, b_rsp_valid, fsm_state} !== 7'd0) begin
      bad++; $display("FAIL mid_async got=%b exp=0000000", {ats_req, busy, a_rsp_valid, b_rsp_valid, fsm_state}); end
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (a_rsp_valid || b_rsp_valid) stray++;
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (a_rsp_valid || b_rsp_valid || ats_req || busy) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL mid_stray got=%0d exp=0", stray); end
    total++; if ({a_ready, b_ready} !== 2'b11) begin bad++; $display("FAIL mid_ready got=%b exp=11", {a_ready, b_ready}); end
  endtask

  initial begin
    reset = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_instr = '0; b_instr = '0;
    ats_ready = 1'b0; ats_stat = '0; ats_data = '0;
    test_reset();
    test_pair();
    test_lone();
    test_late_partner();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
